mem_port_responder: RTL and testbench

//  Memory-side responder for the multicycle CPU's single memory port.

---
 rtl/mem_port_pkg.sv | 23 ++
 rtl/mem_word_array.sv | 26 ++
 rtl/mem_port_responder.sv | 132 +++++++++++++
 tb/tb_mem_port_responder.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// Shared types and helpers for the CPU memory-port responder.
// Defines FSM state encoding and the request address check.
package mem_port_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_DONE,
      WR_DONE,
      ERR
   } mem_rsp_state_t;

   localparam int unsigned WORD_BYTES = 4;

   // Misaligned byte address or word index past the end of storage
   function automatic logic addr_err(
      input logic [31:0] addr,
      input logic [31:0] depth
   );
      return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
   endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word storage behind the memory port.
// Synchronous write, combinational read.
module mem_word_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8,
  parameter string       INIT_FILE   = ""
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_port_responder.sv
// Memory-side responder: one request in flight, fixed read latency,
// registered one-cycle response pulse with error qualifier.
module mem_port_responder
   import mem_port_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned READ_LAT    = 2,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [2:0]  state_dbg
);

   localparam int unsigned AW =
      (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0] CNT_INIT =
      (READ_LAT > 1) ? 4'(READ_LAT - 2) : 4'd0;

   mem_rsp_state_t state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [31:0]    rdata_q, rdata_d;
   logic           valid_q, valid_d;
   logic           err_q, err_d;

   logic [AW-1:0]  req_idx;
   logic [AW-1:0]  rd_idx;
   logic [31:0]    mem_rdata;
   logic           req_err;
   logic           accept;
   logic           mem_we;

   assign req_idx = req_addr[AW+1:2];
   assign req_err = addr_err(req_addr, DEPTH_WORDS);
   assign accept  = req_valid && (state_q == IDLE);
   assign mem_we  = accept && req_we && !req_err;

   // With READ_LAT == 1 the data is fetched on the accepting edge itself
   assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;

   mem_word_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW),
      .INIT_FILE  (INIT_FILE)
   ) u_array (
      .clk_i  (clk),
      .we_i   (mem_we),
      .waddr_i(req_idx),
      .wdata_i(req_wdata),
      .raddr_i(rd_idx),
      .rdata_o(mem_rdata)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (req_err) begin
                  state_d = ERR;
               end else if (req_we) begin
                  state_d = WR_DONE;
               end else begin
                  idx_d = req_idx;
                  if (READ_LAT == 1) begin
                     state_d = RD_DONE;
                  end else begin
                     state_d = RD_WAIT;
                     cnt_d   = CNT_INIT;
                  end
               end
            end
         end
         RD_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RD_DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RD_DONE, WR_DONE, ERR: state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   always_comb begin
      valid_d = (state_d == RD_DONE) ||
                (state_d == WR_DONE) ||
                (state_d == ERR);
      err_d   = (state_d == ERR);
      rdata_d = rdata_q;
      if (state_d == RD_DONE) begin
         rdata_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         rdata_q <= 32'd0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rdata_q <= rdata_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = valid_q;
   assign rsp_err   = err_q;
   assign rsp_rdata = rdata_q;
   assign state_dbg = state_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder at READ_LAT 2, 1 and 5.
// Responses are checked against a queue of expected results.
module tb_mem_port_responder;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        rv  [3];
   logic        rdy [3];
   logic        rsv [3];
   logic        rse [3];
   logic [31:0] rd  [3];
   logic [2:0]  sd  [3];

   exp_t        sbq [$];
   logic [31:0] shm [3][256];
   logic [31:0] lastrd [3];
   int          errors = 0;
   int          checks = 0;
   int          acc_cnt = 0;

   always #5 clk = ~clk;

   mem_port_responder #(.READ_LAT(2)) dut0 (
      .clk(clk), .reset(reset), .req_valid(rv[0]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[0]),
      .rsp_valid(rsv[0]), .rsp_rdata(rd[0]), .rsp_err(rse[0]),
      .state_dbg(sd[0])
   );

   mem_port_responder #(.READ_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(rv[1]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[1]),
      .rsp_valid(rsv[1]), .rsp_rdata(rd[1]), .rsp_err(rse[1]),
      .state_dbg(sd[1])
   );

   mem_port_responder #(.READ_LAT(5)) dut2 (
      .clk(clk), .reset(reset), .req_valid(rv[2]), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy[2]),
      .rsp_valid(rsv[2]), .rsp_rdata(rd[2]), .rsp_err(rse[2]),
      .state_dbg(sd[2])
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int d, input logic v, input logic w,
                        input logic [31:0] a, input logic [31:0] wd);
      rv[d]     = v;
      req_we    = w;
      req_addr  = a;
      req_wdata = wd;
   endtask

   // One clock: log acceptances, then check any response pulses
   task automatic tick();
      exp_t e;
      logic [7:0] idx;
      for (int i = 0; i < 3; i++) begin
         if (rv[i] && rdy[i] && !reset) begin
            idx   = req_addr[9:2];
            e.err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'd256);
            e.data = lastrd[i];
            if (!e.err && req_we) begin
               shm[i][idx] = req_wdata;
            end else if (!e.err) begin
               e.data    = shm[i][idx];
               lastrd[i] = e.data;
            end
            sbq.push_back(e);
            acc_cnt++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (rsv[i] === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("sb_unexpected", {31'd0, rsv[i]}, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("sb_err", {31'd0, rse[i]}, {31'd0, e.err});
               chk("sb_rdata", rd[i], e.data);
            end
         end
      end
   endtask

   task automatic do_req(input int d, input logic w, input logic [31:0] a,
                         input logic [31:0] wd);
      drive(d, 1'b1, w, a, wd);
      tick();
      rv[d] = 1'b0;
      for (int n = 0; n < 20 && sbq.size() != 0; n++) tick();
      chk("drain", sbq.size(), 32'd0);
      tick();
      chk("back_idle", {31'd0, rdy[d]}, 32'd1);
   endtask

   initial begin
      logic [31:0] hl [4];
      int          a0;
      for (int i = 0; i < 3; i++) begin
         rv[i]     = 1'b0;
         lastrd[i] = 32'd0;
      end
      reset     = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_ready", {31'd0, rdy[0]}, 32'd1);
      chk("rst_valid", {31'd0, rsv[0]}, 32'd0);
      chk("rst_err", {31'd0, rse[0]}, 32'd0);
      chk("rst_rdata", rd[0], 32'd0);
      chk("rst_state", {29'd0, sd[0]}, 32'd0);
      reset = 1'b0;

      // Write timing
      drive(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
      tick();
      rv[0] = 1'b0;
      chk("wr_ready_busy", {31'd0, rdy[0]}, 32'd0);
      chk("wr_valid", {31'd0, rsv[0]}, 32'd1);
      chk("wr_err", {31'd0, rse[0]}, 32'd0);
      tick();
      chk("wr_ready_back", {31'd0, rdy[0]}, 32'd1);
      chk("wr_valid_low", {31'd0, rsv[0]}, 32'd0);

      // Read timing at latency 2
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      tick();
      rv[0] = 1'b0;
      chk("rd2_ready_e1", {31'd0, rdy[0]}, 32'd0);
      chk("rd2_valid_e1", {31'd0, rsv[0]}, 32'd0);
      tick();
      chk("rd2_ready_e2", {31'd0, rdy[0]}, 32'd0);
      chk("rd2_valid_e2", {31'd0, rsv[0]}, 32'd1);
      chk("rd2_data", rd[0], 32'hDEADBEEF);
      tick();
      chk("rd2_ready_e3", {31'd0, rdy[0]}, 32'd1);
      chk("rd2_valid_e3", {31'd0, rsv[0]}, 32'd0);

      // Error requests and boundary index
      do_req(0, 1'b1, 32'h3FC, 32'h12345678);
      do_req(0, 1'b1, 32'h000, 32'h0BADF00D);
      do_req(0, 1'b0, 32'h12, 32'h0);
      do_req(0, 1'b1, 32'h400, 32'hFFFFFFFF);
      do_req(0, 1'b1, 32'h3FE, 32'hEEEEEEEE);
      do_req(0, 1'b0, 32'h3FC, 32'h0);
      do_req(0, 1'b0, 32'h000, 32'h0);
      do_req(0, 1'b0, 32'h400, 32'h0);

      // Read straight after a write to the same word
      do_req(0, 1'b1, 32'h30, 32'h31415926);
      do_req(0, 1'b0, 32'h30, 32'h0);

      // Continuous req_valid with a new address every cycle
      for (int k = 0; k < 4; k++) begin
         hl[k] = 32'h20 + 32'(4 * k);
         do_req(0, 1'b1, hl[k], 32'hA0000000 + 32'(k));
      end
      a0 = acc_cnt;
      for (int k = 0; k < 9; k++) begin
         drive(0, 1'b1, 1'b0, hl[k % 4], 32'h0);
         tick();
      end
      rv[0] = 1'b0;
      for (int n = 0; n < 20 && sbq.size() != 0; n++) tick();
      chk("hold_drain", sbq.size(), 32'd0);
      chk("hold_accepts", 32'(acc_cnt - a0), 32'd3);
      tick();

      // Reset while waiting on read data
      drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
      tick();
      rv[0] = 1'b0;
      chk("mid_state", {29'd0, sd[0]}, 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_state", {29'd0, sd[0]}, 32'd0);
      chk("mid_rst_ready", {31'd0, rdy[0]}, 32'd1);
      chk("mid_rst_valid", {31'd0, rsv[0]}, 32'd0);
      chk("mid_rst_rdata", rd[0], 32'd0);
      sbq.delete();
      lastrd[0] = 32'd0;
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("post_rst_valid", {31'd0, rsv[0]}, 32'd0);
      do_req(0, 1'b0, 32'h10, 32'h0);
      chk("post_rst_data", rd[0], 32'hDEADBEEF);

      // Latency 1
      do_req(1, 1'b1, 32'h10, 32'hCAFE0001);
      drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
      tick();
      rv[1] = 1'b0;
      chk("rd1_valid_e1", {31'd0, rsv[1]}, 32'd1);
      chk("rd1_data", rd[1], 32'hCAFE0001);
      tick();
      chk("rd1_ready_e2", {31'd0, rdy[1]}, 32'd1);
      chk("rd1_valid_e2", {31'd0, rsv[1]}, 32'd0);

      // Latency 5
      do_req(2, 1'b1, 32'h3FC, 32'hCAFE0005);
      drive(2, 1'b1, 1'b0, 32'h3FC, 32'h0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         rv[2] = 1'b0;
         chk($sformatf("rd5_valid_e%0d", k), {31'd0, rsv[2]}, 32'd0);
         chk($sformatf("rd5_ready_e%0d", k), {31'd0, rdy[2]}, 32'd0);
      end
      tick();
      chk("rd5_valid_e5", {31'd0, rsv[2]}, 32'd1);
      chk("rd5_data", rd[2], 32'hCAFE0005);
      tick();
      chk("rd5_valid_e6", {31'd0, rsv[2]}, 32'd0);
      chk("rd5_ready_e6", {31'd0, rdy[2]}, 32'd1);

      chk("final_queue", sbq.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
